// File: rtl/median3_unit.sv
// Pipelined median-of-three filter: two-stage datapath, fill/run state tracking
// and a saturating count of accepted samples.
module median3_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     word0,
    input  logic [WIDTH-1:0]     word1,
    input  logic [WIDTH-1:0]     word2,
    output logic [WIDTH-1:0]     median_word,
    output logic                 median_valid,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             clear;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] w2_q;
    logic             v1_q;

    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] min_hw2;
    logic [WIDTH-1:0] median_d;

    // Either reset source clears the whole unit; rst simply wins when both are active.
    assign clear = rst | ~rst_n;

    // Stage-1 sort of the first two words, stage-2 median selection.
    always_comb begin
        lo_d     = (word0 < word1) ? word0 : word1;
        hi_d     = (word0 < word1) ? word1 : word0;
        min_hw2  = (hi_q < w2_q) ? hi_q : w2_q;
        median_d = (lo_q > min_hw2) ? lo_q : min_hw2;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Datapath, counter and status registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            lo_q         <= '0;
            hi_q         <= '0;
            w2_q         <= '0;
            v1_q         <= 1'b0;
            median_word  <= '0;
            median_valid <= 1'b0;
            sample_count <= '0;
            busy         <= 1'b0;
        end else begin
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            w2_q         <= word2;
            v1_q         <= 1'b1;
            median_word  <= median_d;
            median_valid <= v1_q;
            busy         <= (state_d != IDLE);
            if (sample_count != {CNT_WIDTH{1'b1}}) begin
                sample_count <= sample_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
